pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the datapath payload (operands, PC, immediate).
REQ-002 Parameter CTRL_W, default 16: width of the control payload (write enables, ALU control, selects).
REQ-003 Parameter SKID_EN, default 1: 1 adds a second entry (skid buffer); 0 gives a single-entry stage.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  kills every entry held in the stage (bubble insertion).
REQ-007 in_valid  input  1  upstream offers an entry.
REQ-008 in_ready  output  1  stage accepts the offered entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  control payload of the offered entry.
REQ-010 in_data  input  DATA_W  datapath payload of the offered entry.
REQ-011 out_valid  output  1  out_ctrl/out_data hold a live entry.
REQ-012 out_ready  input  1  downstream accepts the entry this cycle (deasserted = stall).
REQ-013 out_ctrl  output  CTRL_W  control payload of the head entry.
REQ-014 out_data  output  DATA_W  datapath payload of the head entry.
REQ-015 occupancy  output  2  number of live entries (0..2; never exceeds 1 when SKID_EN=0).
REQ-016 stall_cnt  output  16  saturating count of stall cycles.
REQ-017 flush_cnt  output  16  saturating count of flushes that killed at least one entry.

Function
REQ-018 Upstream transfer = in_valid && in_ready; downstream transfer = out_valid && out_ready.
REQ-019 Latency is one cycle: an entry accepted at edge N appears on out_* after edge N when the head is empty or is being drained.
REQ-020 SKID_EN=1: in_ready shall be a register output equal to !skid_valid, with no combinational path from out_ready.
REQ-021 SKID_EN=0: in_ready shall be !out_valid || out_ready.
REQ-022 If an upstream transfer occurs while the head is valid and out_ready=0, the entry shall be written to the skid register; occupancy becomes 2 and in_ready drops next cycle.
REQ-023 On a downstream transfer with the skid valid, the head shall load the skid entry; a simultaneous upstream transfer shall go to the skid register.
REQ-024 Entries leave in arrival order; no entry is duplicated or dropped except by flush.
REQ-025 While out_valid=1 and out_ready=0, out_ctrl and out_data shall hold their values.
REQ-026 flush=1 shall clear out_valid and the skid valid bit, zero out_ctrl, out_data and the skid payload, and drop any same-cycle upstream entry; occupancy=0 next cycle.
REQ-027 When flush and stall coincide, flush wins (matches the stage flush-over-stall priority).
REQ-028 When out_valid=0, out_ctrl shall be all-zero so that the downstream stage sees no write enables.
REQ-029 stall_cnt shall increment by 1 each cycle with out_valid=1, out_ready=0, flush=0, and saturate at 16'hFFFF.
REQ-030 flush_cnt shall increment by 1 in each cycle with flush=1 and occupancy!=0, and saturate at 16'hFFFF.
REQ-031 occupancy shall be out_valid + skid_valid, registered state only.

Reset
REQ-032 With rst=1 at an edge, out_valid, skid valid, out_ctrl, out_data, the skid payload, stall_cnt and flush_cnt shall be 0.
REQ-033 in_ready shall be 1 after reset (SKID_EN=1), and rst shall take priority over flush and every transfer.
REQ-034 Asserting rst mid-operation, including with occupancy=2, shall discard all entries; outputs match REQ-032 after the edge.

Verification
REQ-035 Streaming: SKID_EN=1, out_ready=1, in_valid=1 with in_data=1,2,3,... -> out_data=1,2,3 one cycle behind and occupancy=1 throughout.
REQ-036 Backpressure: send A=0xA, B=0xB, then out_ready=0 -> occupancy=2, in_ready=0, out_data holds 0xA; release -> 0xA then 0xB, and stall_cnt equals the number of stalled cycles.
REQ-037 Flush at full: occupancy=2 with in_valid=1 and flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, flush_cnt=1, and the offered entry is absent from the output.
REQ-038 Flush on empty: occupancy=0 with flush=1 -> flush_cnt unchanged at 0.
REQ-039 SKID_EN=0: head valid, out_ready=0 -> in_ready=0 in the same cycle; set out_ready=1 -> in_ready=1 in that cycle, and the new entry is accepted.
REQ-040 Saturation and reset: hold a stall for 70000 cycles -> stall_cnt=16'hFFFF; then rst=1 for one cycle with occupancy=2 -> all outputs 0 and in_ready=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   One pipeline stage register carrying a control payload and a datapath
//   payload between two valid/ready handshakes. With SKID_EN=1 a second
//   (skid) entry absorbs the one extra beat that upstream may send while the
//   head is stalled. Because of the skid entry, in_ready can be a plain
//   register output and the long out_ready -> in_ready combinational path is
//   broken. With SKID_EN=0 the stage holds a single entry and in_ready is
//   combinational. A flush kills every held entry. Saturating counters
//   record stall cycles and flushes that actually killed something.
//
// Parameters:
//   DATA_W   width of the datapath payload (operands, PC, immediate)
//   CTRL_W   width of the control payload (write enables, ALU ctrl, selects)
//   SKID_EN  1 = two-entry stage with skid buffer, 0 = single-entry stage
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset, beats flush and transfers
//   flush      in   kill all held entries and any same-cycle upstream entry
//   in_valid   in   upstream offers an entry
//   in_ready   out  stage accepts the offered entry this cycle
//   in_ctrl    in   control payload of the offered entry
//   in_data    in   datapath payload of the offered entry
//   out_valid  out  out_ctrl/out_data hold a live entry
//   out_ready  in   downstream accepts the head entry (low = stall)
//   out_ctrl   out  control payload of the head entry, zero when not valid
//   out_data   out  datapath payload of the head entry
//   occupancy  out  number of live entries (0..2)
//   stall_cnt  out  saturating count of stall cycles
//   flush_cnt  out  saturating count of flushes that killed an entry
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 16,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    localparam bit          HAS_SKID = (SKID_EN != 0);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // Head entry (what downstream sees) and skid entry (second in line)
    logic              r_headValid;
    logic [CTRL_W-1:0] r_headCtrl;
    logic [DATA_W-1:0] r_headData;
    logic              r_skidValid;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic [DATA_W-1:0] r_skidData;
    logic              r_inReady;
    logic [15:0]       r_stallCnt;
    logic [15:0]       r_flushCnt;

    logic              w_upXfer;
    logic              w_stall;
    logic              w_flushHit;
    logic              w_headValidNext;
    logic [CTRL_W-1:0] w_headCtrlNext;
    logic [DATA_W-1:0] w_headDataNext;
    logic              w_skidValidNext;
    logic [CTRL_W-1:0] w_skidCtrlNext;
    logic [DATA_W-1:0] w_skidDataNext;

    // With a skid entry, in_ready is just "skid slot free", taken straight
    // from a register so out_ready never reaches upstream in the same cycle.
    // Without one, the single slot is free when empty or being drained.
    assign in_ready = HAS_SKID ? r_inReady : (!r_headValid || out_ready);

    assign w_upXfer   = in_valid && in_ready;
    assign w_stall    = r_headValid && !out_ready && !flush;
    assign w_flushHit = flush && (r_headValid || r_skidValid);

    assign out_valid = r_headValid;
    assign out_ctrl  = r_headCtrl;
    assign out_data  = r_headData;
    assign occupancy = {1'b0, r_headValid} + {1'b0, r_skidValid};
    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;

    // Next-state for the two entries. Payloads are zeroed whenever an entry
    // goes empty so a dead head never presents write enables downstream.
    // The skid entry can only be valid while the head is valid, so an empty
    // head simply takes the upstream entry directly.
    always_comb begin
        w_headValidNext = r_headValid;
        w_headCtrlNext  = r_headCtrl;
        w_headDataNext  = r_headData;
        w_skidValidNext = r_skidValid;
        w_skidCtrlNext  = r_skidCtrl;
        w_skidDataNext  = r_skidData;

        if (flush) begin
            w_headValidNext = 1'b0;
            w_headCtrlNext  = '0;
            w_headDataNext  = '0;
            w_skidValidNext = 1'b0;
            w_skidCtrlNext  = '0;
            w_skidDataNext  = '0;
        end else if (!r_headValid) begin
            if (w_upXfer) begin
                w_headValidNext = 1'b1;
                w_headCtrlNext  = in_ctrl;
                w_headDataNext  = in_data;
            end
        end else if (out_ready) begin
            if (r_skidValid) begin
                // Head drains; the older skid entry moves up to keep order.
                w_headCtrlNext = r_skidCtrl;
                w_headDataNext = r_skidData;
                if (w_upXfer) begin
                    w_skidCtrlNext = in_ctrl;
                    w_skidDataNext = in_data;
                end else begin
                    w_skidValidNext = 1'b0;
                    w_skidCtrlNext  = '0;
                    w_skidDataNext  = '0;
                end
            end else if (w_upXfer) begin
                w_headCtrlNext = in_ctrl;
                w_headDataNext = in_data;
            end else begin
                w_headValidNext = 1'b0;
                w_headCtrlNext  = '0;
                w_headDataNext  = '0;
            end
        end else if (w_upXfer && HAS_SKID) begin
            // Head is stalled; park the arriving entry behind it.
            w_skidValidNext = 1'b1;
            w_skidCtrlNext  = in_ctrl;
            w_skidDataNext  = in_data;
        end
    end

    // State registers, including the registered in_ready and the two
    // saturating counters. Reset wins over flush and every transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_headValid <= 1'b0;
            r_headCtrl  <= '0;
            r_headData  <= '0;
            r_skidValid <= 1'b0;
            r_skidCtrl  <= '0;
            r_skidData  <= '0;
            r_inReady   <= 1'b1;
            r_stallCnt  <= '0;
            r_flushCnt  <= '0;
        end else begin
            r_headValid <= w_headValidNext;
            r_headCtrl  <= w_headCtrlNext;
            r_headData  <= w_headDataNext;
            r_skidValid <= w_skidValidNext;
            r_skidCtrl  <= w_skidCtrlNext;
            r_skidData  <= w_skidDataNext;
            r_inReady   <= !w_skidValidNext;
            if (w_stall && (r_stallCnt != CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
            if (w_flushHit && (r_flushCnt != CNT_MAX)) begin
                r_flushCnt <= r_flushCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Purpose:
//   Drives one skid-buffered stage (SKID_EN=1) and one single-entry stage
//   (SKID_EN=0) from the same input stream. A queue-based model of each
//   stage predicts every output every cycle, and directed scenarios add
//   hand-computed expectations at the interesting points.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [15:0] c;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;
    logic        out_ready;

    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_ctrl, s_stall_cnt, s_flush_cnt;
    logic [31:0] s_out_data;
    logic [1:0]  s_occupancy;

    logic        n_in_ready, n_out_valid;
    logic [15:0] n_out_ctrl, n_stall_cnt, n_flush_cnt;
    logic [31:0] n_out_data;
    logic [1:0]  n_occupancy;

    int compCount = 0;
    int failCount = 0;

    // Model state: queues hold entries in arrival order; the skid stage's
    // readiness is a registered "fewer than two held" flag.
    ent_t qS[$];
    ent_t qN[$];
    bit   mInit   = 1'b0;
    bit   mReadyS = 1'b1;
    int   mStS = 0, mFlS = 0, mStN = 0, mFlN = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1)) dutSkid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(0)) dutNoSkid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_ctrl(n_out_ctrl), .out_data(n_out_data),
        .occupancy(n_occupancy), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input logic r, input logic f, input logic iv,
                               input logic [15:0] c, input logic [31:0] d, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [15:0] c, input logic [31:0] d, input logic ordy);
        driveInputs(r, f, iv, c, d, ordy);
        step();
    endtask

    // Behavioural model: at each edge, reset clears everything; flush empties
    // the queue (counting it if anything was held); otherwise a stalled head
    // counts a stall, a ready head pops, and an accepted entry is appended.
    always @(posedge clk) begin
        bit accS, accN;
        if (rst) begin
            qS.delete();
            qN.delete();
            mStS = 0; mFlS = 0; mStN = 0; mFlN = 0;
            mReadyS = 1'b1;
            mInit = 1'b1;
        end else if (mInit) begin
            accS = in_valid && mReadyS;
            accN = in_valid && ((qN.size() == 0) || out_ready);
            if (flush) begin
                if (qS.size() != 0 && mFlS < 65535) mFlS++;
                if (qN.size() != 0 && mFlN < 65535) mFlN++;
                qS.delete();
                qN.delete();
            end else begin
                if (qS.size() != 0 && !out_ready && mStS < 65535) mStS++;
                if (qN.size() != 0 && !out_ready && mStN < 65535) mStN++;
                if (qS.size() != 0 && out_ready) qS.delete(0);
                if (qN.size() != 0 && out_ready) qN.delete(0);
                if (accS) qS.push_back('{c: in_ctrl, d: in_data});
                if (accN) qN.push_back('{c: in_ctrl, d: in_data});
            end
            mReadyS = (qS.size() < 2);
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge
    // so registered outputs and the combinational in_ready are settled.
    always @(negedge clk) begin
        if (mInit) begin
            checkOutput("s_out_valid", 32'(s_out_valid), 32'(qS.size() != 0));
            checkOutput("s_occupancy", 32'(s_occupancy), 32'(qS.size()));
            checkOutput("s_in_ready", 32'(s_in_ready), 32'(mReadyS));
            checkOutput("s_out_ctrl", 32'(s_out_ctrl), (qS.size() != 0) ? 32'(qS[0].c) : 32'd0);
            if (qS.size() != 0) checkOutput("s_out_data", s_out_data, qS[0].d);
            checkOutput("s_stall_cnt", 32'(s_stall_cnt), 32'(mStS));
            checkOutput("s_flush_cnt", 32'(s_flush_cnt), 32'(mFlS));

            checkOutput("n_out_valid", 32'(n_out_valid), 32'(qN.size() != 0));
            checkOutput("n_occupancy", 32'(n_occupancy), 32'(qN.size()));
            checkOutput("n_in_ready", 32'(n_in_ready), 32'((qN.size() == 0) || out_ready));
            checkOutput("n_out_ctrl", 32'(n_out_ctrl), (qN.size() != 0) ? 32'(qN[0].c) : 32'd0);
            if (qN.size() != 0) checkOutput("n_out_data", n_out_data, qN[0].d);
            checkOutput("n_stall_cnt", 32'(n_stall_cnt), 32'(mStN));
            checkOutput("n_flush_cnt", 32'(n_flush_cnt), 32'(mFlN));
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        driveInputs(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        $display("[TB] reset state");
        checkOutput("rst_out_valid", 32'(s_out_valid), 32'd0);
        checkOutput("rst_occupancy", 32'(s_occupancy), 32'd0);
        checkOutput("rst_in_ready", 32'(s_in_ready), 32'd1);
        checkOutput("rst_out_ctrl", 32'(s_out_ctrl), 32'd0);
        checkOutput("rst_out_data", s_out_data, 32'd0);

        // Flush while empty must not count.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 1'b1);
        checkOutput("flush_empty_s_cnt", 32'(s_flush_cnt), 32'd0);
        checkOutput("flush_empty_n_cnt", 32'(n_flush_cnt), 32'd0);

        // Streaming: data i appears one edge after being offered.
        $display("[TB] streaming");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'h8000 | 16'(i), 32'(i), 1'b1);
            checkOutput("stream_s_data", s_out_data, 32'(i));
            checkOutput("stream_s_occ", 32'(s_occupancy), 32'd1);
            checkOutput("stream_n_data", n_out_data, 32'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        checkOutput("drain_s_valid", 32'(s_out_valid), 32'd0);
        checkOutput("drain_s_ctrl", 32'(s_out_ctrl), 32'd0);

        // Backpressure: A in head, B into skid, C refused, three stall edges.
        $display("[TB] backpressure");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h000A, 32'hA, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h000B, 32'hB, 1'b0);
        checkOutput("bp_s_occ", 32'(s_occupancy), 32'd2);
        checkOutput("bp_s_in_ready", 32'(s_in_ready), 32'd0);
        checkOutput("bp_s_data", s_out_data, 32'hA);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h000C, 32'hC, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        checkOutput("bp_hold_s_data", s_out_data, 32'hA);
        checkOutput("bp_hold_s_ctrl", 32'(s_out_ctrl), 32'h000A);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        checkOutput("bp_rel_s_data", s_out_data, 32'hB);
        checkOutput("bp_rel_s_occ", 32'(s_occupancy), 32'd1);
        checkOutput("bp_rel_s_in_ready", 32'(s_in_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        checkOutput("bp_s_stall_cnt", 32'(s_stall_cnt), 32'd3);
        checkOutput("bp_n_stall_cnt", 32'(n_stall_cnt), 32'd3);
        checkOutput("bp_s_empty", 32'(s_occupancy), 32'd0);

        // Flush at full occupancy with a new entry offered the same cycle.
        $display("[TB] flush at full");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0011, 32'h11, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0022, 32'h22, 1'b0);
        checkOutput("ff_s_occ_pre", 32'(s_occupancy), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0033, 32'h33, 1'b0);
        checkOutput("ff_s_valid", 32'(s_out_valid), 32'd0);
        checkOutput("ff_s_ctrl", 32'(s_out_ctrl), 32'd0);
        checkOutput("ff_s_data", s_out_data, 32'd0);
        checkOutput("ff_s_occ", 32'(s_occupancy), 32'd0);
        checkOutput("ff_s_flush_cnt", 32'(s_flush_cnt), 32'd1);
        checkOutput("ff_n_flush_cnt", 32'(n_flush_cnt), 32'd1);
        checkOutput("ff_s_stall_cnt", 32'(s_stall_cnt), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        checkOutput("ff_s_absent", 32'(s_out_valid), 32'd0);

        // Single-entry stage: in_ready follows out_ready within the cycle.
        $display("[TB] single-entry ready path");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0044, 32'h44, 1'b0);
        driveInputs(1'b0, 1'b0, 1'b1, 16'h0055, 32'h55, 1'b0);
        #1;
        checkOutput("ns_in_ready_stall", 32'(n_in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        checkOutput("ns_in_ready_go", 32'(n_in_ready), 32'd1);
        step();
        checkOutput("ns_new_data", n_out_data, 32'h55);
        checkOutput("ns_new_occ", 32'(n_occupancy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);

        // Long stall to saturate stall_cnt, then reset while full.
        $display("[TB] saturation and reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0066, 32'h66, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0077, 32'h77, 1'b0);
        driveInputs(1'b0, 1'b0, 1'b1, 16'h0088, 32'h88, 1'b0);
        for (int i = 0; i < 70000; i++) step();
        checkOutput("sat_s_stall_cnt", 32'(s_stall_cnt), 32'h0000FFFF);
        checkOutput("sat_n_stall_cnt", 32'(n_stall_cnt), 32'h0000FFFF);
        checkOutput("sat_s_occ", 32'(s_occupancy), 32'd2);
        checkOutput("sat_s_data", s_out_data, 32'h66);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0099, 32'h99, 1'b1);
        checkOutput("rst2_s_valid", 32'(s_out_valid), 32'd0);
        checkOutput("rst2_s_occ", 32'(s_occupancy), 32'd0);
        checkOutput("rst2_s_ctrl", 32'(s_out_ctrl), 32'd0);
        checkOutput("rst2_s_data", s_out_data, 32'd0);
        checkOutput("rst2_s_stall_cnt", 32'(s_stall_cnt), 32'd0);
        checkOutput("rst2_s_flush_cnt", 32'(s_flush_cnt), 32'd0);
        checkOutput("rst2_s_in_ready", 32'(s_in_ready), 32'd1);
        checkOutput("rst2_n_stall_cnt", 32'(n_stall_cnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        checkOutput("post_rst_s_valid", 32'(s_out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
